// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, issues one request at a time on the
// req/addr_ok/data_ok instruction-memory interface, buffers a returned word
// while ID is stalled, and applies the single-delay-slot branch redirect.
//
// Handshake: a request is transferred on the cycle inst_req && inst_addr_ok;
// inst_req/inst_addr stay stable until then. A response is transferred on any
// cycle inst_data_ok is high while a request is outstanding (WAIT); data_ok
// seen in any other state is ignored. Only one request is ever outstanding.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic               inst_req,
  output logic [31:0]        inst_addr,
  input  logic               inst_addr_ok,
  input  logic               inst_data_ok,
  input  logic [31:0]        inst_rdata,
  output logic [32:0]        if_to_id_bus,
  output logic [31:0]        if_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic        id_ce_q, id_ce_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  // Stall bits above EX belong to later stages and do not affect fetch.
  logic unused_stall_hi;
  assign unused_stall_hi = |stall[STALL_W-1:3];

  logic        stall_if, stall_id, stall_ex;
  logic        br_e;
  logic [31:0] br_addr;
  assign stall_if = stall[0];
  assign stall_id = stall[1];
  assign stall_ex = stall[2];
  assign br_e     = br_bus[32];
  assign br_addr  = br_bus[31:0];

  // Request outputs come straight from the FSM state and the fetch PC.
  assign inst_req     = (state_q == S_REQ);
  assign inst_addr    = (state_q == S_REQ) ? fetch_pc_q : 32'd0;
  assign if_to_id_bus = {id_ce_q, id_pc_q};
  assign if_inst      = id_inst_q;

  logic        br_capture;
  logic        pend_eff;
  logic [31:0] tgt_eff;
  logic [31:0] ds_eff;
  logic        redirect;
  logic [31:0] next_pc;
  logic        data_take;
  logic        buf_valid_now;
  logic [31:0] buf_now;
  logic [31:0] buf_pc_now;

  // Next-state logic: FSM, next-PC with same-cycle branch capture, buffer, ID register.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    last_pc_d   = last_pc_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    ds_pc_d     = ds_pc_q;
    id_ce_d     = id_ce_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;

    // A branch is taken into account exactly once: when it leaves ID.
    br_capture = id_ce_q && br_e && !stall_ex;
    pend_eff   = br_capture || br_pend_q;
    tgt_eff    = br_capture ? br_addr : br_tgt_q;
    ds_eff     = br_capture ? (id_pc_q + 32'd4) : ds_pc_q;
    br_pend_d  = pend_eff;
    br_tgt_d   = tgt_eff;
    ds_pc_d    = ds_eff;

    // Once the delay slot has been fetched, the next fetch goes to the target.
    redirect = pend_eff && (last_pc_q == ds_eff);
    next_pc  = redirect ? tgt_eff : (last_pc_q + 32'd4);

    // A response arriving this cycle is visible to the ID load (bypass).
    data_take     = (state_q == S_WAIT) && inst_data_ok;
    buf_valid_now = buf_valid_q || data_take;
    buf_now       = data_take ? inst_rdata : buf_q;
    buf_pc_now    = data_take ? last_pc_q : buf_pc_q;
    buf_valid_d   = buf_valid_now;
    buf_d         = buf_now;
    buf_pc_d      = buf_pc_now;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (inst_addr_ok) begin
          state_d   = S_WAIT;
          last_pc_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (!stall_if) begin
            fetch_pc_d = next_pc;
            state_d    = S_REQ;
            if (redirect) br_pend_d = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_if && !buf_valid_q) begin
          fetch_pc_d = next_pc;
          state_d    = S_REQ;
          if (redirect) br_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ID register: bubble when ID stalls but EX moves on, hold when both stall.
    if (stall_id && !stall_ex) begin
      id_ce_d   = 1'b0;
      id_pc_d   = 32'd0;
      id_inst_d = 32'd0;
    end else if (stall_id) begin
      id_ce_d   = id_ce_q;
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
    end else if (buf_valid_now) begin
      id_ce_d     = 1'b1;
      id_pc_d     = buf_pc_now;
      id_inst_d   = buf_now;
      buf_valid_d = 1'b0;
    end else begin
      id_ce_d   = 1'b0;
      id_pc_d   = 32'd0;
      id_inst_d = 32'd0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      last_pc_q   <= 32'd0;
      buf_q       <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_valid_q <= 1'b0;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= 32'd0;
      ds_pc_q     <= 32'd0;
      id_ce_q     <= 1'b0;
      id_pc_q     <= 32'd0;
      id_inst_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      last_pc_q   <= last_pc_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
      ds_pc_q     <= ds_pc_d;
      id_ce_q     <= id_ce_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a memory responder and an ID-stage stand-in drive the
// DUT; a transaction-level model predicts the fetch address stream and the
// ordered stream of {pc, inst} deliveries to ID.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .if_to_id_bus(if_to_id_bus), .if_inst(if_inst)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0004) return 32'h3C01_1234;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- model / scoreboard ----------------
  logic [63:0] exp_q[$];          // {pc, inst} fetched and not yet delivered
  logic        m_have_last;
  logic [31:0] m_last;            // last accepted fetch address
  logic        m_out;             // request outstanding
  logic [31:0] m_out_addr;
  int          m_lat;
  logic        m_br;
  logic [31:0] m_br_ds, m_br_tgt;
  logic        m_req_pend;
  logic [31:0] m_req_addr;
  int          m_req_wait;
  logic        m_expect_req;
  logic [32:0] e_bus;
  logic [31:0] e_inst;
  logic        m_new_dlv;
  logic        cur_is_br, prev_was_br;
  logic [31:0] cur_br_tgt;

  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];
  logic [31:0] dlv_inst_log[$];
  int first_req_cyc, first_dlv_cyc, first_req_run;
  logic first_acc_done;

  // Knobs
  logic        do_reset;
  int          k_addr_ok_delay, k_data_lat, k_stall_on_data, k_stall_on_br;
  logic [31:0] k_stall_addr, k_br_pc, k_br_tgt;
  logic        k_rand_stall, k_rand_br, k_br_en, k_stale;
  int          stall_cnt;
  logic [5:0]  stall_hold;

  function automatic logic [31:0] next_fetch();
    if (!m_have_last) return RESET_PC;
    if (m_br && m_last == m_br_ds) return m_br_tgt;
    return m_last + 32'd4;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dlv_at(input int i);
    if (i < dlv_log.size()) return dlv_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dlv_inst_at(input int i);
    if (i < dlv_inst_log.size()) return dlv_inst_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_have_last = 0; m_last = 0; m_out = 0; m_out_addr = 0; m_lat = 0;
    m_br = 0; m_br_ds = 0; m_br_tgt = 0;
    m_req_pend = 0; m_req_addr = 0; m_req_wait = 0; m_expect_req = 0;
    e_bus = '0; e_inst = '0; m_new_dlv = 0;
    cur_is_br = 0; prev_was_br = 0; cur_br_tgt = 0; stall_cnt = 0;
  endtask

  task automatic clear_logs();
    acc_log.delete(); dlv_log.delete(); dlv_inst_log.delete();
    first_req_cyc = -1; first_dlv_cyc = -1; first_req_run = 0; first_acc_done = 0;
  endtask

  task automatic set_defaults();
    k_addr_ok_delay = 0; k_data_lat = 0; k_stall_on_data = 0; k_stall_on_br = 0;
    k_stall_addr = 0; k_br_pc = 0; k_br_tgt = 0;
    k_rand_stall = 0; k_rand_br = 0; k_br_en = 0; k_stale = 0; do_reset = 0;
  endtask

  // ---------------- one clock cycle: compare, drive, advance model ----------------
  task automatic step();
    logic        acc, dat;
    logic [63:0] d;
    int          r;
    int          k;
    // compare process: outputs produced by the previous edge
    chk("id_bus", 64'(if_to_id_bus), 64'(e_bus));
    chk("if_inst", 64'(if_inst), 64'(e_inst));
    chk("one_outstanding", 64'(inst_req & m_out), 64'd0);
    if (m_req_pend) begin
      chk("req_hold", 64'(inst_req), 64'd1);
      chk("addr_hold", 64'(inst_addr), 64'(m_req_addr));
    end else if (inst_req) begin
      chk("req_addr", 64'(inst_addr), 64'(next_fetch()));
    end
    if (m_expect_req) chk("req_after_data", 64'(inst_req), 64'd1);
    if (inst_req && first_req_cyc < 0) first_req_cyc = cyc;

    // ID stand-in: decide whether the newly delivered instruction is a branch
    if (m_new_dlv) begin
      prev_was_br = cur_is_br;
      cur_is_br = 0;
      if (k_br_en && e_bus[31:0] == k_br_pc) begin
        cur_is_br = 1; cur_br_tgt = k_br_tgt;
      end else if (k_rand_br && !prev_was_br && $urandom_range(0, 3) == 0) begin
        cur_is_br = 1; cur_br_tgt = RESET_PC + (32'($urandom_range(0, 63)) << 2);
      end
      if (cur_is_br && k_stall_on_br > 0) begin
        stall_cnt = k_stall_on_br; stall_hold = 6'b000111;
      end
    end
    if (e_bus[32] && cur_is_br) br_bus = {1'b1, cur_br_tgt};
    else if (e_bus[32])         br_bus = {1'b0, 32'($urandom)};
    else if (k_rand_br)         br_bus = {1'($urandom_range(0, 1)), 32'($urandom)};
    else                        br_bus = '0;

    // memory responder
    if (inst_req) begin
      if (k_addr_ok_delay >= 0) inst_addr_ok = (m_req_wait >= k_addr_ok_delay);
      else                      inst_addr_ok = ($urandom_range(0, 2) != 0);
    end else begin
      inst_addr_ok = 1'b0;
    end
    if (m_out) begin
      if (m_lat == 0) inst_data_ok = 1'b1;
      else begin inst_data_ok = 1'b0; m_lat--; end
    end else begin
      inst_data_ok = k_stale;
    end
    inst_rdata = (inst_data_ok && m_out) ? mem_word(m_out_addr) : 32'($urandom);
    if (inst_data_ok && m_out && k_stall_on_data > 0 && m_out_addr == k_stall_addr) begin
      stall_cnt = k_stall_on_data; stall_hold = 6'b000111;
    end

    // stall controller stand-in: stalls are always a prefix (a stalled stage stalls all earlier ones)
    if (stall_cnt > 0) begin
      stall = stall_hold; stall_cnt--;
    end else if (k_rand_stall) begin
      r = $urandom_range(0, 9);
      k = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      stall = 6'((1 << k) - 1);
    end else begin
      stall = '0;
    end
    rst = do_reset;

    // model: effect of the coming edge
    if (do_reset) begin
      model_reset();
    end else begin
      acc = inst_req & inst_addr_ok;
      dat = inst_data_ok & m_out;
      m_expect_req = 0;
      m_new_dlv = 0;
      if (dat) begin
        exp_q.push_back({m_out_addr, mem_word(m_out_addr)});
        m_out = 0;
        m_expect_req = !stall[0];
      end
      if (acc) begin
        m_out_addr = next_fetch();
        if (m_have_last && m_br && m_last == m_br_ds) m_br = 0;
        m_have_last = 1;
        m_last = m_out_addr;
        m_out = 1;
        m_lat = (k_data_lat >= 0) ? k_data_lat : $urandom_range(0, 2);
        m_req_pend = 0;
        m_req_wait = 0;
        acc_log.push_back(inst_addr);
        if (!first_acc_done) first_req_run++;
        first_acc_done = 1;
      end else if (inst_req) begin
        m_req_pend = 1;
        m_req_addr = inst_addr;
        m_req_wait++;
        if (!first_acc_done) first_req_run++;
      end
      // branch leaves ID: redirect after its delay slot
      if (e_bus[32] && br_bus[32] && !stall[2]) begin
        m_br = 1; m_br_ds = e_bus[31:0] + 32'd4; m_br_tgt = br_bus[31:0];
      end
      // ID register
      if (stall[1] && !stall[2]) begin
        e_bus = '0; e_inst = '0;
      end else if (!stall[1]) begin
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          e_bus = {1'b1, d[63:32]}; e_inst = d[31:0];
          m_new_dlv = 1;
          dlv_log.push_back(d[63:32]);
          dlv_inst_log.push_back(d[31:0]);
          if (first_dlv_cyc < 0) first_dlv_cyc = cyc + 1;
        end else begin
          e_bus = '0; e_inst = '0;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut();
    do_reset = 1;
    step();
    do_reset = 0;
    clear_logs();
  endtask

  // ---------------- tests ----------------
  initial begin
    int cnt;
    int guard;
    set_defaults();
    rst = 1'b1; stall = '0; br_bus = '0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    stall_hold = '0;
    model_reset();
    clear_logs();
    @(negedge clk);
    @(negedge clk);
    // reset values
    chk("rst_req", 64'(inst_req), 64'd0);
    chk("rst_addr", 64'(inst_addr), 64'd0);
    chk("rst_bus", 64'(if_to_id_bus), 64'd0);
    chk("rst_inst", 64'(if_inst), 64'd0);

    // 1: zero-wait sequential fetch and latency
    reset_dut();
    run(12);
    chk("t1_acc0", 64'(acc_at(0)), 64'h0000_0000_BFC0_0000);
    chk("t1_acc1", 64'(acc_at(1)), 64'h0000_0000_BFC0_0004);
    chk("t1_acc2", 64'(acc_at(2)), 64'h0000_0000_BFC0_0008);
    chk("t1_dlv0", 64'(dlv_at(0)), 64'h0000_0000_BFC0_0000);
    chk("t1_latency", 64'(first_dlv_cyc - first_req_cyc), 64'd2);

    // 2: addr_ok delayed three cycles
    set_defaults(); k_addr_ok_delay = 3;
    reset_dut();
    run(24);
    chk("t2_req_cycles", 64'(first_req_run), 64'd4);
    chk("t2_dlv0", 64'(dlv_at(0)), 64'h0000_0000_BFC0_0000);
    chk("t2_dlv1", 64'(dlv_at(1)), 64'h0000_0000_BFC0_0004);
    cnt = 0;
    foreach (dlv_log[i]) if (dlv_log[i] == 32'hBFC0_0000) cnt++;
    chk("t2_single_dlv", 64'(cnt), 64'd1);

    // 3: ID stalled for four cycles while a word returns
    set_defaults(); k_stall_on_data = 4; k_stall_addr = 32'hBFC0_0004;
    reset_dut();
    run(24);
    chk("t3_dlv1_pc", 64'(dlv_at(1)), 64'h0000_0000_BFC0_0004);
    chk("t3_dlv1_inst", 64'(dlv_inst_at(1)), 64'h0000_0000_3C01_1234);
    chk("t3_dlv2_pc", 64'(dlv_at(2)), 64'h0000_0000_BFC0_0008);
    chk("t3_acc2", 64'(acc_at(2)), 64'h0000_0000_BFC0_0008);
    cnt = 0;
    foreach (dlv_log[i]) if (dlv_log[i] == 32'hBFC0_0004) cnt++;
    chk("t3_single_dlv", 64'(cnt), 64'd1);

    // 4: branch at 0xBFC00010 -> 0xBFC00100, zero-wait memory
    set_defaults(); k_br_en = 1; k_br_pc = 32'hBFC0_0010; k_br_tgt = 32'hBFC0_0100;
    reset_dut();
    run(30);
    chk("t4_acc5_ds", 64'(acc_at(5)), 64'h0000_0000_BFC0_0014);
    chk("t4_acc6_tgt", 64'(acc_at(6)), 64'h0000_0000_BFC0_0100);
    chk("t4_acc7", 64'(acc_at(7)), 64'h0000_0000_BFC0_0104);
    chk("t4_dlv5_ds", 64'(dlv_at(5)), 64'h0000_0000_BFC0_0014);

    // 5: branch captured while the delay slot fetch is in WAIT (2-cycle data)
    set_defaults(); k_br_en = 1; k_br_pc = 32'hBFC0_0010; k_br_tgt = 32'hBFC0_0100;
    k_data_lat = 1; k_stall_on_br = 1;
    reset_dut();
    run(40);
    chk("t5_acc5_ds", 64'(acc_at(5)), 64'h0000_0000_BFC0_0014);
    chk("t5_acc6_tgt", 64'(acc_at(6)), 64'h0000_0000_BFC0_0100);
    chk("t5_acc7", 64'(acc_at(7)), 64'h0000_0000_BFC0_0104);
    cnt = 0;
    foreach (acc_log[i]) if (acc_log[i] == 32'hBFC0_0018) cnt++;
    chk("t5_no_0x18", 64'(cnt), 64'd0);

    // 6: reset while waiting for data; stale data_ok afterwards
    set_defaults(); k_data_lat = 3;
    reset_dut();
    guard = 0;
    while (!(m_out && m_lat > 0) && guard < 20) begin step(); guard++; end
    chk("t6_reached_wait", 64'(guard < 20), 64'd1);
    k_stale = 1;
    do_reset = 1;
    step();
    do_reset = 0;
    clear_logs();
    chk("t6_req_after_rst", 64'(inst_req), 64'd0);
    chk("t6_bus_after_rst", 64'(if_to_id_bus), 64'd0);
    run(3);
    k_stale = 0;
    run(12);
    chk("t6_acc0", 64'(acc_at(0)), 64'h0000_0000_BFC0_0000);
    chk("t6_dlv0_inst", 64'(dlv_inst_at(0)), 64'(mem_word(32'hBFC0_0000)));

    // 7: randomized traffic, stalls and branches
    set_defaults();
    k_addr_ok_delay = -1; k_data_lat = -1; k_rand_stall = 1; k_rand_br = 1;
    reset_dut();
    run(4000);
    chk("rand_progress", 64'(dlv_log.size() > 200), 64'd1);
    k_rand_stall = 0; k_rand_br = 0; k_addr_ok_delay = 0; k_data_lat = 0;
    run(20);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch stage: owns the PC and issues requests on a request/response instruction-memory interface.
- Delivers {ce, pc} plus the fetched instruction word to the ID stage.
- Consumes ID's branch bus {br_e, br_addr} and applies the MIPS one-delay-slot redirect.
- Holds at most one outstanding memory request; buffers a returned instruction while ID is stalled.

Parameters:
RESET_PC, 32'hBFC0_0000, address of the first fetch after reset
STALL_W, 6, width of stall bus; bit0 = IF, bit1 = ID, bit2 = EX; 1 = Stop

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  STALL_W  pipeline stall vector from the stall controller
br_bus  in  33  {br_e[32], br_addr[31:0]} from ID
inst_req  out  1  memory request valid
inst_addr  out  32  request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response valid this cycle
inst_rdata  in  32  response data, valid with inst_data_ok
if_to_id_bus  out  33  {ce[32], pc[31:0]}; ce=0 marks a bubble
if_inst  out  32  instruction paired with if_to_id_bus

Behaviour:
- Reset: state=IDLE, inst_req=0, inst_addr=0, if_to_id_bus=0, if_inst=0, fetch_pc=RESET_PC, last_pc=0, buf_valid=0, br_pend=0.
- States:
  - IDLE: first cycle after reset deassert, go to REQ.
  - REQ: inst_req=1 and inst_addr=fetch_pc (combinational from state/reg). On inst_addr_ok go to WAIT and set last_pc=fetch_pc. Hold req and addr stable until accepted.
  - WAIT: inst_req=0. On inst_data_ok capture inst_rdata into buf with buf_pc=last_pc, buf_valid=1.
  - From WAIT, on the data_ok cycle:
    - If stall[0]==NoStop, compute the next fetch_pc and go to REQ.
    - Otherwise go to HOLD.
  - HOLD: inst_req=0. When stall[0]==NoStop and buf_valid==0, compute next fetch_pc and go to REQ.
- Next-PC rule, evaluated on leaving WAIT/HOLD:
  - If br_pend and last_pc == ds_pc: next = br_tgt, clear br_pend.
  - Otherwise next = last_pc + 4 (wraps modulo 2^32).
- Branch capture:
  - Sample br_bus only when if_to_id_bus.ce==1, br_e==1 and stall[2]==NoStop (branch leaves ID this cycle). Exactly one capture per branch.
  - On capture: br_pend=1, br_tgt=br_addr, ds_pc=if_to_id_bus.pc+4.
  - Delay slot is always fetched and delivered. No flush of the delay slot.
- ID output register:
  - If stall[1]==Stop and stall[2]==NoStop: load 0 (bubble).
  - Else if stall[1]==Stop: hold.
  - Else if buf_valid (including data_ok captured this cycle, bypassed): load {1, buf_pc} and if_inst=buf, clear buf_valid.
  - Else load ce=0, pc=0, if_inst=0.
- Latency: request to ID output is 1 cycle after data_ok when unstalled (zero-wait memory: req at T, addr_ok at T, data_ok at T+1, output valid at T+2).
- Simultaneous events:
  - data_ok and ID-stall in the same cycle: data goes to buf, not lost.
  - Branch capture in the same cycle as next-PC computation: the captured values participate in that computation.
- data_ok in IDLE/REQ is ignored. The memory side is reset together with rst.
- Reset mid-transaction (REQ/WAIT/HOLD): all state returns to reset values next cycle; refetch starts at RESET_PC.

Test Plan:
- Reset, zero-wait memory -> inst_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008; if_to_id_bus={1,0xBFC00000} two cycles after first req.
- addr_ok delayed 3 cycles -> inst_req and inst_addr held constant for 3 cycles; single WAIT transition; no duplicate delivery.
- stall[1]=Stop for 4 cycles while data_ok returns 0x3C011234 -> if_to_id_bus/if_inst hold; buffered word delivered exactly once after release; fetch resumes at next PC.
- Branch at 0xBFC00010, br_e=1 with br_addr=0xBFC00100 -> delay slot 0xBFC00014 delivered, next request 0xBFC00100, then 0xBFC00104.
- Branch captured while the delay-slot fetch is already in WAIT with 2-cycle data latency -> target still issued immediately after delay slot; no fetch of 0xBFC00018.
- rst asserted in WAIT -> next cycle inst_req=0, if_to_id_bus=0; stale data_ok ignored; first new request addr=0xBFC00000.
